// File: rtl/zpu_sd_multi_bridge.sv
// Multi-image sector bridge: ZPU firmware registers <-> HPS per-slot sector requests,
// with mount-event queue, request timeout and a shared dual-port sector buffer.
module zpu_sd_multi_bridge #(
  parameter int          NUM_IMG = 4,
  parameter int          BLK_AW  = 9,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [31:0]        ZPU_OUT2,
  input  logic [31:0]        ZPU_OUT3,
  input  logic               ZPU_DATA_WR,
  input  logic               ZPU_DATA_RD,
  input  logic               ZPU_IO_WR,
  output logic [15:0]        ZPU_IN2,
  output logic [31:0]        ZPU_IN3,
  output logic [31:0]        SD_LBA,
  output logic [NUM_IMG-1:0] SD_RD,
  output logic [NUM_IMG-1:0] SD_WR,
  input  logic [NUM_IMG-1:0] SD_ACK,
  input  logic [BLK_AW-1:0]  SD_BUFF_ADDR,
  input  logic [7:0]         SD_BUFF_DOUT,
  output logic [7:0]         SD_BUFF_DIN,
  input  logic               SD_BUFF_WR,
  input  logic [NUM_IMG-1:0] IMG_MOUNTED,
  input  logic               IMG_READONLY,
  input  logic [63:0]        IMG_SIZE,
  input  logic [7:0]         IOCTL_INDEX
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

  state_t              state_q, state_d;
  logic [3:1]          ctl_q;
  logic [1:0]          wr_sync_q;
  logic                rd_q;
  logic [NUM_IMG-1:0]  mnt_q;
  logic [NUM_IMG-1:0]  mnt_rise;
  logic [NUM_IMG-1:0]  pending_q, pending_d;
  logic [31:0]         size_q [0:7];
  logic [1:0]          ftype_q [0:7];
  logic                ro_q [0:7];
  logic [2:0]          rep_slot;
  logic [BLK_AW-1:0]   ptr_q, ptr_d;
  logic                inc_q;
  logic [31:0]         lba_q;
  logic [NUM_IMG-1:0]  sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic [NUM_IMG-1:0]  req_mask;
  logic [2:0]          slot_q, slot_d;
  logic [23:0]         tcnt_q, tcnt_d;
  logic                io_done_q, io_done_d;
  logic                terr_q, terr_d;
  logic [7:0]          ack_x;
  logic [7:0]          ram [0:(2**BLK_AW)-1];
  logic [7:0]          ram_a_q, ram_b_q;

  logic [2:0] s_in;
  logic       slot_ok, rd_edge, wr_edge, ack_edge, data_wr_rise, rd_fall, zpu_we;
  logic       unused_bits;

  assign s_in         = ZPU_OUT2[6:4];
  assign slot_ok      = int'(s_in) < NUM_IMG;
  assign rd_edge      = ZPU_OUT2[1] & ~ctl_q[1];
  assign wr_edge      = ZPU_OUT2[2] & ~ctl_q[2];
  assign ack_edge     = ZPU_OUT2[3] & ~ctl_q[3];
  assign data_wr_rise = wr_sync_q[0] & ~wr_sync_q[1];
  assign rd_fall      = rd_q & ~ZPU_DATA_RD;
  assign zpu_we       = data_wr_rise & ~ZPU_OUT2[0];
  assign req_mask     = NUM_IMG'(1) << s_in;
  assign mnt_rise     = IMG_MOUNTED & ~mnt_q;
  assign unused_bits  = ^{IMG_SIZE[63:32], IOCTL_INDEX[5:0], ZPU_OUT2[31:7]};

  // Widen the per-slot ack to 8 bits so the 3-bit latched slot can index it safely.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ack
      if (gi < NUM_IMG) begin : g_used
        assign ack_x[gi] = SD_ACK[gi];
      end else begin : g_pad
        assign ack_x[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    rep_slot = 3'd0;
    for (int i = NUM_IMG - 1; i >= 0; i--) begin
      if (pending_q[i]) rep_slot = 3'(i);
    end
  end

  // A new mount on the slot being acknowledged survives the clear.
  always_comb begin
    pending_d = pending_q;
    if (ack_edge) pending_d = pending_d & ~(NUM_IMG'(1) << rep_slot);
    pending_d = pending_d | mnt_rise;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ZPU_IO_WR) ptr_d = '0;
    else           ptr_d = ptr_q + BLK_AW'(inc_q) + BLK_AW'(rd_fall);
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    tcnt_d    = tcnt_q;
    io_done_d = io_done_q;
    terr_d    = terr_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    case (state_q)
      ST_IDLE: begin
        if ((rd_edge || wr_edge) && slot_ok) begin
          slot_d    = s_in;
          tcnt_d    = '0;
          io_done_d = 1'b0;
          terr_d    = 1'b0;
          if (rd_edge) sd_rd_d = req_mask;
          else         sd_wr_d = req_mask;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_x[slot_q]) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          state_d = ST_XFER;
        end else if (tcnt_q == TIMEOUT - 24'd1) begin
          sd_rd_d   = '0;
          sd_wr_d   = '0;
          terr_d    = 1'b1;
          io_done_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + 24'd1;
        end
      end
      ST_XFER: begin
        if (!ack_x[slot_q]) begin
          io_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      ctl_q     <= '0;
      wr_sync_q <= '0;
      rd_q      <= 1'b0;
      mnt_q     <= '0;
      pending_q <= '0;
      ptr_q     <= '0;
      inc_q     <= 1'b0;
      lba_q     <= '0;
      sd_rd_q   <= '0;
      sd_wr_q   <= '0;
      slot_q    <= '0;
      tcnt_q    <= '0;
      io_done_q <= 1'b1;
      terr_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        size_q[i]  <= '0;
        ftype_q[i] <= '0;
        ro_q[i]    <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      ctl_q     <= ZPU_OUT2[3:1];
      wr_sync_q <= {wr_sync_q[0], ZPU_DATA_WR};
      rd_q      <= ZPU_DATA_RD;
      mnt_q     <= IMG_MOUNTED;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      inc_q     <= zpu_we;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      slot_q    <= slot_d;
      tcnt_q    <= tcnt_d;
      io_done_q <= io_done_d;
      terr_q    <= terr_d;
      if (data_wr_rise && ZPU_OUT2[0]) lba_q <= ZPU_OUT3;
      for (int i = 0; i < NUM_IMG; i++) begin
        if (mnt_rise[i]) begin
          size_q[i]  <= IMG_SIZE[31:0];
          ftype_q[i] <= IOCTL_INDEX[7:6];
          ro_q[i]    <= IMG_READONLY;
        end
      end
    end
  end

  // Shared sector buffer: port A is the HPS side, port B follows the ZPU pointer.
  always_ff @(posedge CLK) begin
    if (SD_BUFF_WR) ram[SD_BUFF_ADDR] <= SD_BUFF_DOUT;
    if (zpu_we)     ram[ptr_q]        <= ZPU_OUT3[7:0];
    ram_a_q <= ram[SD_BUFF_ADDR];
    ram_b_q <= ram[ptr_q];
  end

  assign SD_RD       = sd_rd_q;
  assign SD_WR       = sd_wr_q;
  assign SD_LBA      = lba_q;
  assign SD_BUFF_DIN = ram_a_q;
  assign ZPU_IN2     = {7'd0, terr_q, ro_q[rep_slot], ftype_q[rep_slot], rep_slot,
                        |pending_q, io_done_q};
  assign ZPU_IN3     = ZPU_OUT2[0] ? size_q[rep_slot] : {24'd0, ram_b_q};

endmodule

// File: tb/tb_zpu_sd_multi_bridge.sv
// Directed self-checking bench for zpu_sd_multi_bridge (NUM_IMG=4, BLK_AW=9, TIMEOUT=16).
module tb_zpu_sd_multi_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] out2, out3;
  logic        data_wr, data_rd, io_wr;
  logic [15:0] in2;
  logic [31:0] in3, sd_lba;
  logic [3:0]  sd_rd, sd_wr, sd_ack;
  logic [8:0]  buff_addr;
  logic [7:0]  buff_dout, buff_din;
  logic        buff_wr;
  logic [3:0]  img_mounted;
  logic        img_ro;
  logic [63:0] img_size;
  logic [7:0]  ioctl_index;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zpu_sd_multi_bridge #(.NUM_IMG(4), .BLK_AW(9), .TIMEOUT(24'd16)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .ZPU_OUT2(out2), .ZPU_OUT3(out3),
    .ZPU_DATA_WR(data_wr), .ZPU_DATA_RD(data_rd), .ZPU_IO_WR(io_wr),
    .ZPU_IN2(in2), .ZPU_IN3(in3),
    .SD_LBA(sd_lba), .SD_RD(sd_rd), .SD_WR(sd_wr), .SD_ACK(sd_ack),
    .SD_BUFF_ADDR(buff_addr), .SD_BUFF_DOUT(buff_dout), .SD_BUFF_DIN(buff_din),
    .SD_BUFF_WR(buff_wr),
    .IMG_MOUNTED(img_mounted), .IMG_READONLY(img_ro), .IMG_SIZE(img_size),
    .IOCTL_INDEX(ioctl_index)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_mount_ack();
    out2 = 32'h08;
    tick();
    out2 = 32'h00;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; out2 = '0; out3 = '0; data_wr = 0; data_rd = 0; io_wr = 0;
    sd_ack = '0; buff_addr = '0; buff_dout = '0; buff_wr = 0;
    img_mounted = '0; img_ro = 0; img_size = '0; ioctl_index = '0;
    repeat (3) tick();
    chk("reset_in2", in2, 16'h0001);
    chk("reset_sd_rd", sd_rd, 4'b0000);
    chk("reset_sd_wr", sd_wr, 4'b0000);
    chk("reset_lba", sd_lba, 32'h0);
    rst_n = 1'b1;
    tick();
    $display("phase reset done");

    // Mount slot 2: pending, rep_slot 2, filetype 1
    img_size = 64'h4000; ioctl_index = 8'h40; img_ro = 0; img_mounted = 4'b0100;
    tick();
    img_mounted = '0;
    chk("mount2_in2", in2, 16'h002B);
    out2 = 32'h01;
    #1;
    chk("mount2_size", in3, 32'h4000);
    out2 = 32'h00;
    pulse_mount_ack();
    chk("ack2_in2", in2, 16'h0001);

    // Mount slots 3 and 1 together, readonly, filetype 2
    img_size = 64'h100; ioctl_index = 8'h80; img_ro = 1; img_mounted = 4'b1010;
    tick();
    img_mounted = '0;
    chk("mount31_in2", in2, 16'h00C7);
    pulse_mount_ack();
    chk("ack1_in2", in2, 16'h00CF);
    pulse_mount_ack();
    chk("ack3_in2", in2, 16'h0001);
    $display("phase mount done");

    // LBA write then block read on slot 1
    out2 = 32'h01; out3 = 32'h1234; data_wr = 1;
    tick();
    data_wr = 0;
    repeat (4) tick();
    chk("lba", sd_lba, 32'h1234);
    out2 = 32'h10;
    tick();
    out2 = 32'h12;
    tick();
    chk("req_sd_rd", sd_rd, 4'b0010);
    chk("req_io_done", in2[0], 1'b0);
    sd_ack = 4'b0010;
    for (int i = 0; i < 512; i++) begin
      buff_addr = 9'(i); buff_dout = 8'(i); buff_wr = 1;
      if (i == 100) out2 = 32'h10;
      if (i == 101) out2 = 32'h12;
      tick();
      if (i == 0)   chk("ack_drop_rd", sd_rd, 4'b0000);
      if (i == 102) chk("xfer_reedge_ignored", sd_rd, 4'b0000);
    end
    buff_wr = 0;
    chk("xfer_busy", in2[0], 1'b0);
    sd_ack = '0;
    tick();
    chk("xfer_done", in2[0], 1'b1);
    buff_addr = 9'd5;
    repeat (2) tick();
    chk("hps_readback", buff_din, 8'h05);
    $display("phase block read done");

    // Rewind and read the buffer back through the pointer, including the wrap
    out2 = 32'h10; io_wr = 1;
    tick();
    io_wr = 0;
    tick();
    chk("rewind_in3", in3, 32'h0);
    for (int i = 0; i < 512; i++) begin
      data_rd = 1;
      tick();
      data_rd = 0;
      repeat (2) tick();
      chk("ptr_read", in3, 32'((i + 1) & 8'hFF));
    end
    $display("phase pointer read done");

    // ZPU data write at ptr 0, pointer advance, HPS-side readback
    out2 = 32'h00; out3 = 32'hA5; io_wr = 1;
    tick();
    io_wr = 0; data_wr = 1;
    tick();
    data_wr = 0;
    repeat (4) tick();
    chk("zpu_wr_ptr_adv", in3, 32'h01);
    io_wr = 1;
    tick();
    io_wr = 0;
    repeat (2) tick();
    chk("zpu_wr_data", in3, 32'hA5);
    buff_addr = 9'd0;
    repeat (2) tick();
    chk("zpu_wr_hps", buff_din, 8'hA5);
    $display("phase zpu write done");

    // Write request on slot 0 with no ack: timeout after 16 cycles
    out2 = 32'h04;
    tick();
    chk("to_sd_wr_set", sd_wr, 4'b0001);
    chk("to_busy", in2[0], 1'b0);
    for (int j = 1; j < 16; j++) begin
      tick();
      chk("to_sd_wr_hold", sd_wr, 4'b0001);
    end
    tick();
    chk("to_sd_wr_drop", sd_wr, 4'b0000);
    chk("to_in2", in2, 16'h0101);
    out2 = 32'h00;
    tick();
    out2 = 32'h02;
    tick();
    chk("to_err_cleared", in2[8], 1'b0);
    chk("to_next_rd", sd_rd, 4'b0001);
    sd_ack = 4'b0001;
    tick();
    sd_ack = '0;
    tick();
    chk("to_next_done", in2[0], 1'b1);
    $display("phase timeout done");

    // Drive select beyond NUM_IMG is ignored
    out2 = 32'h50;
    tick();
    out2 = 32'h52;
    tick();
    chk("bad_slot_rd", sd_rd, 4'b0000);
    chk("bad_slot_done", in2[0], 1'b1);
    $display("phase bad slot done");

    // Asynchronous reset while in REQ
    out2 = 32'h10;
    tick();
    out2 = 32'h12;
    tick();
    chk("rst_req_rd", sd_rd, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_rd", sd_rd, 4'b0000);
    out2 = 32'h00;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in2", in2, 16'h0001);
    $display("phase reset mid-request done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/zpu_sd_multi_bridge.md
# zpu_sd_multi_bridge

Multi-image block-I/O bridge between the ZPU firmware register file (OUT2/OUT3/IN2/IN3 and RD/WR strobes) and the HPS sector interface. It generalises the single-image sector bridge to NUM_IMG independently mounted images, and adds:

- a queued mount-event mask with explicit firmware acknowledge,
- a per-request ack timeout with an error flag.

It sits in the emu top level between hps_io and atari*top, and owns the shared sector buffer RAM.

## Interface
Parameters:
- NUM_IMG, 4: number of image slots, 1..8.
- BLK_AW, 9: sector-buffer address width (2^BLK_AW bytes).
- TIMEOUT, 24'hFFFFFF: cycles allowed in REQ without ack before abort, ≥2.

Ports:
- CLK in 1: system clock; sole clock.
- RESET_N in 1: asynchronous, active-low reset.
- ZPU_OUT2 in 32: control bits, decoded as follows.
  - [0] lba_sel
  - [1] block_rd
  - [2] block_wr
  - [3] mount_ack
  - [6:4] drive select
- ZPU_OUT3 in 32: data / LBA from firmware.
- ZPU_DATA_WR in 1: write strobe, any length ≥1 cycle.
- ZPU_DATA_RD in 1: read strobe.
- ZPU_IO_WR in 1: rewinds buffer pointer.
- ZPU_IN2 out 16: status, decoded as follows.
  - [0] io_done
  - [1] mount_pending
  - [4:2] rep_slot
  - [6:5] filetype
  - [7] readonly
  - [8] timeout_err
  - [15:9] 0
- ZPU_IN3 out 32: lba_sel ? size of rep_slot : {24'b0, buffer byte at pointer}.
- SD_LBA out 32: shared LBA.
- SD_RD out NUM_IMG: read request, one bit per slot.
- SD_WR out NUM_IMG: write request, one bit per slot.
- SD_ACK in NUM_IMG: per-slot acknowledge.
- SD_BUFF_ADDR in BLK_AW: HPS-side buffer address.
- SD_BUFF_DOUT in 8: HPS-side write data.
- SD_BUFF_DIN out 8: HPS-side read data, one-cycle RAM latency.
- SD_BUFF_WR in 1: HPS-side write enable.
- IMG_MOUNTED in NUM_IMG: mount pulses.
- IMG_READONLY in 1: readonly flag for the mount event.
- IMG_SIZE in 64: image size for the mount event.
- IOCTL_INDEX in 8: file index; [7:6] gives filetype.

## Operation
Mount tracking:
- Rising edge of IMG_MOUNTED[i] sets pending[i] and latches size[i] = IMG_SIZE[31:0], type[i] = IOCTL_INDEX[7:6], ro[i] = IMG_READONLY.
- rep_slot = lowest set bit of pending, else 0.
- mount_pending = |pending.
- A rising edge of OUT2[3] clears pending[rep_slot].
- If the set and the clear hit the same slot in the same cycle, the set wins.

Buffer pointer ptr (BLK_AW bits):
- ZPU_DATA_WR is passed through a 2-FF delay; a detected rising edge acts as follows.
  - lba_sel = 1: SD_LBA <= OUT3.
  - lba_sel = 0: write OUT3[7:0] at ptr, then ptr+1 on the following cycle.
- Falling edge of ZPU_DATA_RD: ptr+1.
- ZPU_IO_WR = 1: ptr <= 0. This has priority over any increment in the same cycle.
- ptr wraps from 2^BLK_AW-1 to 0.

Request FSM, states IDLE, REQ, XFER:
- Slot s = OUT2[6:4]. If s ≥ NUM_IMG the request is ignored and io_done stays 1.
- IDLE: a rising edge of OUT2[1] or OUT2[2] sets SD_RD[s] or SD_WR[s] respectively. It also clears io_done and timeout_err, loads tcnt = 0 and moves to REQ.
  - If both edges occur together, the read wins.
  - Request edges outside IDLE are ignored; there is no queuing.
- REQ: SD_ACK[s] = 1 → drop SD_RD/SD_WR and go to XFER. Otherwise tcnt+1.
  - When tcnt == TIMEOUT-1: drop the requests, set timeout_err = 1 and io_done = 1, go to IDLE.
- XFER: SD_ACK[s] falling → io_done = 1, go to IDLE.
- The latched s is used throughout the transfer; changes to OUT2[6:4] after the start have no effect.

Buffer:
- True dual-port RAM.
- Port A belongs to HPS.
- Port B belongs to the ZPU pointer.

## Timing
- Reset values:
  - SD_RD = 0, SD_WR = 0, SD_LBA = 0.
  - io_done = 1, pending = 0, timeout_err = 0.
  - ptr = 0, FSM = IDLE.
  - ZPU_IN2 = 16'h0001.
  - RAM contents are not reset.
- Reset asserted mid-transfer drops SD_RD/SD_WR asynchronously. It does not wait for SD_ACK.
- Request latency: with OUT2[1] sampled 1 at edge k and 0 at edge k-1, SD_RD[s] and io_done = 0 are visible after edge k.
- Ack handling: SD_ACK sampled high at edge m → request bit low after edge m. SD_ACK sampled low at edge n in XFER → io_done = 1 after edge n.
- ZPU data write: the RAM write occurs 2 edges after ZPU_DATA_WR rises. ptr increments at the edge after the write.
- ZPU_IN3 buffer data is valid 1 cycle after ptr changes.
- Mount: pending visible 1 cycle after the IMG_MOUNTED edge.

## Test plan
- Reset, then idle: ZPU_IN2 = 16'h0001, SD_RD = 0, SD_WR = 0. Pulse IMG_MOUNTED[2] with IMG_SIZE = 0x4000 and IOCTL_INDEX = 8'h40: IN2[1] = 1, IN2[4:2] = 2, IN2[6:5] = 1; with lba_sel = 1, IN3 = 0x4000.
- Mount slots 3 and 1 together: rep_slot = 1. Pulse mount_ack: rep_slot = 3. Pulse mount_ack again: IN2[1] = 0.
- Write LBA 0x1234 (lba_sel = 1), set drive select = 1, raise block_rd: SD_LBA = 0x1234, SD_RD = 4'b0010, io_done = 0. Raise SD_ACK[1] for 512 cycles while HPS writes bytes i&0xFF: SD_RD drops the cycle after the ack, io_done rises the cycle after the ack falls. Pulse IO_WR, then 512 read strobes: IN3 = 0, 1, 2, …; the pointer wraps to 0.
- TIMEOUT = 16, block_wr on slot 0 with no ack: SD_WR[0] stays high for 16 cycles, then 0, with IN2[8] = 1 and io_done = 1. The next request clears IN2[8].
- A second block_rd edge during XFER is ignored (SD_RD stays 0). Drive select 5 with NUM_IMG = 4: no request issued.
- Assert RESET_N = 0 while in REQ: SD_RD clears immediately, and IN2 = 16'h0001 after release.
